// File: rtl/mem_log_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_log_ctrl
// Purpose  : Decimating N_CH-channel capture logger with one-shot and circular
//            pre/post-trigger modes, internal RAM and 2-cycle readback.
// Revision : 1.0 - initial release
// ============================================================================
module mem_log_ctrl #(
    parameter int ADDR_WIDTH   = 15,
    parameter int SAMPLE_WIDTH = 8,
    parameter int N_CH         = 2,
    parameter int DEC_WIDTH    = 8
) (
    input  logic                         clk,
    input  logic                         i_rst_n,
    input  logic [N_CH*SAMPLE_WIDTH-1:0] i_samples,
    input  logic                         i_sample_valid,
    input  logic                         i_run_log,
    input  logic                         i_abort,
    input  logic                         i_mode,
    input  logic                         i_trigger,
    input  logic [ADDR_WIDTH-1:0]        i_post_count,
    input  logic [DEC_WIDTH-1:0]         i_decim,
    input  logic                         i_read_log,
    input  logic [ADDR_WIDTH-1:0]        i_addr_log_to_mem,
    output logic                         o_busy,
    output logic                         o_triggered,
    output logic                         o_mem_full,
    output logic [ADDR_WIDTH-1:0]        o_start_addr,
    output logic [31:0]                  o_data_log_from_mem,
    output logic                         o_data_valid
);

    localparam int                    c_DATA_WIDTH = N_CH * SAMPLE_WIDTH;
    localparam int                    c_DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR  = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_FULL  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_mode;
    logic [DEC_WIDTH-1:0]    r_decim;
    logic [ADDR_WIDTH-1:0]   r_post_count;
    logic [ADDR_WIDTH-1:0]   r_post_left;
    logic [ADDR_WIDTH-1:0]   r_wr_ptr;
    logic                    r_wrapped;
    logic [DEC_WIDTH-1:0]    r_dec_cnt;
    logic                    r_triggered;
    logic                    r_rd_pend;
    logic                    r_valid;
    logic [31:0]             r_data;
    logic [c_DATA_WIDTH-1:0] r_ram_q;
    logic [c_DATA_WIDTH-1:0] r_mem [c_DEPTH];

    logic                    w_capture;
    logic                    w_start;
    logic                    w_keep;
    logic                    w_write;
    logic                    w_trig;
    logic                    w_read;
    logic [ADDR_WIDTH-1:0]   w_start_addr;
    logic [ADDR_WIDTH-1:0]   w_ram_addr;

    assign w_capture = (r_state == S_RUN) || (r_state == S_ARMED) || (r_state == S_POST);
    assign w_start   = ((r_state == S_IDLE) || (r_state == S_FULL)) && i_run_log && !i_abort;
    assign w_keep    = w_capture && i_sample_valid && !i_abort;
    assign w_write   = w_keep && (r_dec_cnt == '0);
    assign w_trig    = (r_state == S_ARMED) && i_trigger && !i_abort;
    // A restart request in FULL takes precedence over a same-cycle read.
    assign w_read    = (r_state == S_FULL) && i_read_log && !i_abort && !i_run_log;

    // Oldest word sits at the write pointer once a circular capture has wrapped.
    assign w_start_addr = ((r_state == S_FULL) && r_mode && r_wrapped) ? r_wr_ptr : '0;
    assign w_ram_addr   = w_write ? r_wr_ptr : (w_start_addr + i_addr_log_to_mem);

    always_comb begin
        w_state_nxt = r_state;
        if (i_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_FULL: begin
                    if (i_run_log) w_state_nxt = i_mode ? S_ARMED : S_RUN;
                end
                S_RUN: begin
                    if (w_write && (r_wr_ptr == c_LAST_ADDR)) w_state_nxt = S_FULL;
                end
                S_ARMED: begin
                    if (i_trigger) w_state_nxt = (r_post_count == '0) ? S_FULL : S_POST;
                end
                S_POST: begin
                    if (w_write && (r_post_left == ADDR_WIDTH'(1))) w_state_nxt = S_FULL;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode       <= 1'b0;
            r_decim      <= '0;
            r_post_count <= '0;
            r_post_left  <= '0;
            r_wr_ptr     <= '0;
            r_wrapped    <= 1'b0;
            r_dec_cnt    <= '0;
            r_triggered  <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_valid      <= 1'b0;
            r_data       <= '0;
        end else begin
            if (w_start) begin
                r_mode       <= i_mode;
                r_decim      <= i_decim;
                r_post_count <= i_post_count;
                r_wr_ptr     <= '0;
                r_wrapped    <= 1'b0;
                r_dec_cnt    <= '0;
                r_triggered  <= 1'b0;
            end else begin
                if (w_keep) begin
                    if (r_dec_cnt == '0) begin
                        r_dec_cnt <= r_decim;
                        r_wr_ptr  <= r_wr_ptr + ADDR_WIDTH'(1);
                        if (r_wr_ptr == c_LAST_ADDR) r_wrapped <= 1'b1;
                    end else begin
                        r_dec_cnt <= r_dec_cnt - DEC_WIDTH'(1);
                    end
                end
                // The trigger-cycle write is pre-trigger, so the countdown starts afterwards.
                if (w_trig) begin
                    r_triggered <= 1'b1;
                    r_post_left <= r_post_count;
                end else if ((r_state == S_POST) && w_write) begin
                    r_post_left <= r_post_left - ADDR_WIDTH'(1);
                end
            end

            r_rd_pend <= w_read;
            if (i_abort || w_start) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else begin
                r_valid <= r_rd_pend;
                if (r_rd_pend) r_data <= 32'(r_ram_q);
            end
        end
    end

    // Capture RAM: writes happen only while capturing and reads only in FULL.
    always_ff @(posedge clk) begin
        if (w_write) r_mem[w_ram_addr] <= i_samples;
        if (w_read)  r_ram_q <= r_mem[w_ram_addr];
    end

    assign o_busy              = w_capture;
    assign o_triggered         = r_triggered;
    assign o_mem_full          = (r_state == S_FULL);
    assign o_start_addr        = w_start_addr;
    assign o_data_log_from_mem = r_data;
    assign o_data_valid        = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_log_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_log_ctrl
// Purpose  : Self-checking bench for mem_log_ctrl with a sample-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_log_ctrl;

    localparam int AW    = 4;
    localparam int SW    = 8;
    localparam int NC    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic [NC*SW-1:0]  i_samples = '0;
    logic              i_sample_valid = 1'b0;
    logic              i_run_log = 1'b0;
    logic              i_abort = 1'b0;
    logic              i_mode = 1'b0;
    logic              i_trigger = 1'b0;
    logic [AW-1:0]     i_post_count = '0;
    logic [DW-1:0]     i_decim = '0;
    logic              i_read_log = 1'b0;
    logic [AW-1:0]     i_addr_log_to_mem = '0;
    logic              o_busy;
    logic              o_triggered;
    logic              o_mem_full;
    logic [AW-1:0]     o_start_addr;
    logic [31:0]       o_data_log_from_mem;
    logic              o_data_valid;

    int checks = 0;
    int failures = 0;

    mem_log_ctrl #(
        .ADDR_WIDTH  (AW),
        .SAMPLE_WIDTH(SW),
        .N_CH        (NC),
        .DEC_WIDTH   (DW)
    ) dut (
        .clk                (clk),
        .i_rst_n            (i_rst_n),
        .i_samples          (i_samples),
        .i_sample_valid     (i_sample_valid),
        .i_run_log          (i_run_log),
        .i_abort            (i_abort),
        .i_mode             (i_mode),
        .i_trigger          (i_trigger),
        .i_post_count       (i_post_count),
        .i_decim            (i_decim),
        .i_read_log         (i_read_log),
        .i_addr_log_to_mem  (i_addr_log_to_mem),
        .o_busy             (o_busy),
        .o_triggered        (o_triggered),
        .o_mem_full         (o_mem_full),
        .o_start_addr       (o_start_addr),
        .o_data_log_from_mem(o_data_log_from_mem),
        .o_data_valid       (o_data_valid)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) step;
        checks++;
        if ({o_busy, o_triggered, o_mem_full, o_data_valid} !== 4'b0000 ||
            o_start_addr !== '0 || o_data_log_from_mem !== 32'h0) begin
            failures++;
            $display("FAIL reset_hold: busy/trig/full/valid=%b start=%0d data=%0h, required 0000 0 0",
                     {o_busy, o_triggered, o_mem_full, o_data_valid}, o_start_addr, o_data_log_from_mem);
        end
        @(negedge clk);
        i_rst_n = 1'b1;
        step;
        checks++;
        if ({o_busy, o_triggered, o_mem_full, o_data_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_release: busy/trig/full/valid=%b, required 0000",
                     {o_busy, o_triggered, o_mem_full, o_data_valid});
        end
    endtask

    // Model: sample k (counted from start) is kept when k % (decim+1) == 0; memory
    // holds the last DEPTH kept samples, oldest first.
    task automatic test_capture(input string nm, input bit mode, input int decim, input int post,
                                input int trig_at, input bit rnd, input bit noise);
        logic [15:0] kept[$];
        int          idx[$];
        logic [15:0] val;
        logic [31:0] exp_data;
        int          vcount, s, post_wr, total, nread, base, budget, exp_start;
        bit          post_phase, done, v, trg;
        vcount = 0; s = 0; post_wr = 0; budget = 0; post_phase = 1'b0; done = 1'b0;

        i_mode = mode; i_decim = DW'(decim); i_post_count = AW'(post);
        i_run_log = 1'b1;
        step;
        i_run_log = 1'b0;
        checks++;
        if ({o_busy, o_mem_full, o_triggered, o_data_valid} !== 4'b1000 || o_data_log_from_mem !== 32'h0) begin
            failures++;
            $display("FAIL %s start: busy/full/trig/valid=%b data=%0h, required 1000 data 0",
                     nm, {o_busy, o_mem_full, o_triggered, o_data_valid}, o_data_log_from_mem);
        end

        while (!done) begin
            v   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            val = rnd ? 16'($urandom) : 16'(s);
            trg = mode && !post_phase && v && (s == trig_at);
            i_sample_valid = v; i_samples = val; i_trigger = trg;
            i_run_log = 1'b0; i_read_log = 1'b0;
            if (noise) begin
                i_run_log         = ($urandom_range(0, 7) == 0);
                i_read_log        = 1'($urandom);
                i_addr_log_to_mem = AW'($urandom);
                i_mode            = 1'($urandom);
                i_decim           = DW'($urandom);
                i_post_count      = AW'($urandom);
                if (!mode || post_phase) i_trigger = trg | ($urandom_range(0, 3) == 0);
            end
            if (v) begin
                if (vcount % (decim + 1) == 0) begin
                    kept.push_back(val);
                    if (post_phase) post_wr++;
                end
                vcount++;
                s++;
            end
            if (trg) begin
                post_phase = 1'b1;
                if (post == 0) done = 1'b1;
            end else if (!mode && kept.size() == DEPTH) begin
                done = 1'b1;
            end else if (post_phase && post_wr == post) begin
                done = 1'b1;
            end
            step;
            budget++;
            checks++;
            if ({o_busy, o_mem_full, o_triggered, o_data_valid} !== {!done, done, post_phase, 1'b0}) begin
                failures++;
                $display("FAIL %s capture cyc %0d: busy/full/trig/valid=%b, required %b",
                         nm, budget, {o_busy, o_mem_full, o_triggered, o_data_valid},
                         {!done, done, post_phase, 1'b0});
            end
            if (budget > 3000) begin
                failures++;
                $display("FAIL %s timeout: capture not complete after %0d cycles, required completion", nm, budget);
                done = 1'b1;
            end
        end
        i_sample_valid = 1'b0; i_trigger = 1'b0; i_run_log = 1'b0; i_read_log = 1'b0;

        total     = kept.size();
        nread     = (total < DEPTH) ? total : DEPTH;
        base      = total - nread;
        exp_start = (mode && total >= DEPTH) ? (total % DEPTH) : 0;
        checks++;
        if (o_start_addr !== AW'(exp_start)) begin
            failures++;
            $display("FAIL %s start_addr: got %0d, required %0d", nm, o_start_addr, exp_start);
        end

        for (int c = 0; c < nread; c++) idx.push_back(rnd ? $urandom_range(0, nread - 1) : c);
        for (int c = 0; c <= nread + 1; c++) begin
            i_read_log        = (c < nread);
            i_addr_log_to_mem = (c < nread) ? AW'(idx[c]) : AW'($urandom);
            step;
            if (c >= 1 && c <= nread) begin
                exp_data = 32'(kept[base + idx[c-1]]);
                checks++;
                if (o_data_valid !== 1'b1 || o_data_log_from_mem !== exp_data) begin
                    failures++;
                    $display("FAIL %s read logical %0d: valid=%b data=%0h, required valid=1 data=%0h",
                             nm, idx[c-1], o_data_valid, o_data_log_from_mem, exp_data);
                end
            end else begin
                exp_data = (c == 0) ? 32'h0 : 32'(kept[base + idx[nread-1]]);
                checks++;
                if (o_data_valid !== 1'b0 || o_data_log_from_mem !== exp_data) begin
                    failures++;
                    $display("FAIL %s read idle %0d: valid=%b data=%0h, required valid=0 data=%0h",
                             nm, c, o_data_valid, o_data_log_from_mem, exp_data);
                end
            end
        end
        checks++;
        if ({o_busy, o_mem_full} !== 2'b01) begin
            failures++;
            $display("FAIL %s after_reads: busy/full=%b, required 01", nm, {o_busy, o_mem_full});
        end
    endtask

    task automatic test_abort;
        // Abort while FULL with a completed read on the output.
        i_read_log = 1'b1; i_addr_log_to_mem = AW'(5);
        step;
        i_read_log = 1'b0;
        step;
        checks++;
        if (o_data_valid !== 1'b1) begin
            failures++;
            $display("FAIL abort_full_read: valid=%b, required 1", o_data_valid);
        end
        i_abort = 1'b1;
        step;
        i_abort = 1'b0;
        checks++;
        if ({o_busy, o_mem_full, o_data_valid} !== 3'b000 || o_data_log_from_mem !== 32'h0) begin
            failures++;
            $display("FAIL abort_full: busy/full/valid=%b data=%0h, required 000 data 0",
                     {o_busy, o_mem_full, o_data_valid}, o_data_log_from_mem);
        end

        // Abort during POST, colliding with a restart and a read request.
        i_mode = 1'b1; i_decim = '0; i_post_count = AW'(10); i_run_log = 1'b1;
        step;
        i_run_log = 1'b0;
        for (int s = 0; s < 7; s++) begin
            i_sample_valid = 1'b1; i_samples = 16'(s); i_trigger = (s == 3);
            step;
        end
        i_sample_valid = 1'b0; i_trigger = 1'b0;
        checks++;
        if ({o_busy, o_triggered, o_mem_full} !== 3'b110) begin
            failures++;
            $display("FAIL abort_pre: busy/trig/full=%b, required 110", {o_busy, o_triggered, o_mem_full});
        end
        i_abort = 1'b1; i_run_log = 1'b1; i_read_log = 1'b1;
        step;
        i_abort = 1'b0; i_run_log = 1'b0;
        checks++;
        if ({o_busy, o_mem_full, o_data_valid} !== 3'b000 || o_start_addr !== '0) begin
            failures++;
            $display("FAIL abort_post: busy/full/valid=%b start=%0d, required 000 start 0",
                     {o_busy, o_mem_full, o_data_valid}, o_start_addr);
        end
        for (int k = 0; k < 4; k++) begin
            i_addr_log_to_mem = AW'($urandom);
            step;
            checks++;
            if ({o_busy, o_mem_full, o_data_valid} !== 3'b000) begin
                failures++;
                $display("FAIL abort_read %0d: busy/full/valid=%b, required 000",
                         k, {o_busy, o_mem_full, o_data_valid});
            end
        end
        i_read_log = 1'b0;
    endtask

    task automatic test_async_reset;
        i_mode = 1'b1; i_decim = '0; i_post_count = AW'(8); i_run_log = 1'b1;
        step;
        i_run_log = 1'b0;
        for (int s = 0; s < 6; s++) begin
            i_sample_valid = 1'b1; i_samples = 16'(s + 100); i_trigger = (s == 2);
            step;
        end
        checks++;
        if ({o_busy, o_triggered, o_mem_full} !== 3'b110) begin
            failures++;
            $display("FAIL async_pre: busy/trig/full=%b, required 110", {o_busy, o_triggered, o_mem_full});
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_triggered, o_mem_full, o_data_valid} !== 4'b0000 ||
            o_start_addr !== '0 || o_data_log_from_mem !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: busy/trig/full/valid=%b start=%0d data=%0h, required 0000 0 0",
                     {o_busy, o_triggered, o_mem_full, o_data_valid}, o_start_addr, o_data_log_from_mem);
        end
        i_sample_valid = 1'b0; i_trigger = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        step;
        checks++;
        if ({o_busy, o_mem_full} !== 2'b00) begin
            failures++;
            $display("FAIL async_release: busy/full=%b, required 00", {o_busy, o_mem_full});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_capture("oneshot",     1'b0, 0, 0,  0,  1'b0, 1'b0);
        test_capture("decim2",      1'b0, 2, 0,  0,  1'b0, 1'b0);
        test_capture("circ_wrap",   1'b1, 0, 4,  20, 1'b0, 1'b0);
        test_capture("circ_early",  1'b1, 0, 2,  3,  1'b0, 1'b0);
        test_capture("circ_post0",  1'b1, 1, 0,  7,  1'b0, 1'b1);
        test_capture("circ_postmx", 1'b1, 0, 15, 25, 1'b0, 1'b1);
        test_abort;
        test_capture("restart",     1'b0, 1, 0,  0,  1'b1, 1'b1);
        test_async_reset;
        test_capture("post_reset",  1'b1, 0, 3,  5,  1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            test_capture($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                         $urandom_range(0, 15), $urandom_range(0, 40), 1'b1, 1'b1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_log_ctrl.md
# mem_log_ctrl

Parametrised multi-channel capture logger: decimates a stream of N_CH packed filter samples, writes them into an internal block RAM, and exposes the capture for word-by-word readback. Sits after the receive filter bank, in place of the single-shot 2-channel logger. Adds decimation, a circular pre/post-trigger mode, abort, a read-valid strobe and an oldest-sample pointer.

## Interface
- ADDR_WIDTH, 15, RAM address width; depth DEPTH = 2^ADDR_WIDTH words
- SAMPLE_WIDTH, 8, bits per channel sample
- N_CH, 2, channels per word; N_CH*SAMPLE_WIDTH <= 32
- DEC_WIDTH, 8, width of decimation setting
- clk  in  1  single clock; all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_samples  in  N_CH*SAMPLE_WIDTH  channel k at [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]
- i_sample_valid  in  1  i_samples valid this cycle
- i_run_log  in  1  start-capture pulse
- i_abort  in  1  abandon capture, return to IDLE
- i_mode  in  1  0 = one-shot fill, 1 = circular with trigger
- i_trigger  in  1  trigger event (mode 1 only)
- i_post_count  in  ADDR_WIDTH  words written after trigger (mode 1)
- i_decim  in  DEC_WIDTH  keep 1 of every i_decim+1 valid samples
- i_read_log  in  1  read request
- i_addr_log_to_mem  in  ADDR_WIDTH  logical read index, 0 = oldest stored word
- o_busy  out  1  capture in progress
- o_triggered  out  1  trigger accepted during current/last capture
- o_mem_full  out  1  capture complete, memory readable
- o_start_addr  out  ADDR_WIDTH  physical address of oldest word
- o_data_log_from_mem  out  32  read data, zero-extended
- o_data_valid  out  1  o_data_log_from_mem valid this cycle

## Operation
- States: IDLE, RUN (mode 0), ARMED (mode 1, pre-trigger), POST (mode 1, post-trigger), FULL.
- i_mode, i_decim, i_post_count latched on accepted i_run_log; later changes ignored until next start.
- i_run_log accepted in IDLE or FULL: clears wr_ptr, wrapped flag, dec_cnt, o_triggered, o_mem_full; goes RUN (mode 0) or ARMED (mode 1). Ignored in RUN/ARMED/POST.
- Decimation: on i_sample_valid in RUN/ARMED/POST: if dec_cnt==0, write word at wr_ptr, wr_ptr+1 (mod DEPTH), dec_cnt <= i_decim; else dec_cnt-1. First valid sample after start is always written.
- RUN: write of address DEPTH-1 -> FULL; o_start_addr = 0.
- ARMED: wr_ptr wraps; wrap from DEPTH-1 to 0 sets wrapped flag. i_trigger -> POST, o_triggered=1, post_left <= latched i_post_count; sample written in the trigger cycle counts as pre-trigger.
- POST: each write decrements post_left; write taking it to 0 -> FULL. post_count of 0 -> FULL the cycle after trigger. Post count saturates at DEPTH-1.
- FULL (mode 1): o_start_addr = wr_ptr if wrapped (or post wrapped) else 0.
- i_trigger ignored in RUN, POST, FULL, IDLE.
- Read: only in FULL. physical = o_start_addr + i_addr_log_to_mem mod DEPTH. i_read_log outside FULL ignored; o_data_valid stays 0.
- i_abort: highest priority in any state; next state IDLE, o_busy=0, o_mem_full=0; captured contents no longer readable.
- Simultaneous i_abort and i_run_log: abort wins. Simultaneous i_trigger and final ARMED write: trigger taken, write counted pre-trigger.
- RAM: internal single-port synchronous, DEPTH x N_CH*SAMPLE_WIDTH; writes and reads never overlap (reads FULL only).

## Timing
- Reset (asynchronous, i_rst_n low): state IDLE; o_busy, o_triggered, o_mem_full, o_data_valid = 0; o_start_addr = 0; o_data_log_from_mem = 0. RAM contents undefined.
- o_busy = 1 the cycle after accepted i_run_log through the cycle of final write.
- o_mem_full rises the cycle after the final write; o_busy falls the same cycle.
- Read latency 2: i_read_log at cycle n -> o_data_valid=1 and data at n+2 (RAM register + output register). One read per cycle, fully pipelined.
- o_data_log_from_mem holds last read value when o_data_valid=0; cleared to 0 on new start or abort.
- o_triggered rises the cycle after accepted trigger.

## Test plan
- ADDR_WIDTH=4, mode 0, i_decim=0, valid every cycle, samples 0..15 -> o_mem_full at cycle 17 after start; reads 0..15 back-to-back return 0..15 with o_data_valid two cycles after each request.
- ADDR_WIDTH=4, mode 0, i_decim=2, samples 0..47 valid -> stored 0,3,6,...,45; logical 5 reads 15.
- ADDR_WIDTH=4, mode 1, i_post_count=4, samples 0..29, trigger with sample 20 -> FULL after sample 24; o_start_addr=9; logical 0..15 read 9..24.
- Mode 1, trigger before wrap (with sample 3), i_post_count=2 -> o_start_addr=0, words 0..5 valid, o_mem_full after sample 5.
- Abort in POST, then i_read_log -> o_data_valid stays 0, o_mem_full 0; new i_run_log restarts cleanly.
- i_rst_n low mid-capture (asynchronous, between edges) -> all outputs 0 immediately; i_run_log ignored while busy verified.
